// File: rtl/vector_imul_lane_dispatcher.sv
// Splits a packed SIMD multiply into per-lane scalar multiplier requests and
// repacks the in-order products into a double-width vector result.
module vector_imul_lane_dispatcher #(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clk_en_i,
    input  logic              data_valid_i,
    input  logic              lane_mode_i,
    input  logic              signed_i,
    input  logic [XLEN-1:0]   vmultiplicand_i,
    input  logic [XLEN-1:0]   vmultiplier_i,
    output logic              busy_o,
    output logic [XLEN-1:0]   imul_operand_a_o,
    output logic [XLEN-1:0]   imul_operand_b_o,
    output logic              imul_signed_o,
    output logic              imul_valid_o,
    input  logic              imul_ready_i,
    input  logic [63:0]       imul_result_i,
    input  logic              imul_valid_i,
    output logic [2*XLEN-1:0] vresult_o,
    output logic              vresult_valid_o
);

    localparam int unsigned W8  = XLEN / 4;
    localparam int unsigned W16 = XLEN / 2;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic              r_mode;
    logic              r_signed;
    logic [2:0]        r_issue_cnt;
    logic [2:0]        r_resp_cnt;
    logic [2:0]        r_outstanding;
    logic [2*XLEN-1:0] r_vresult;

    logic [2:0]        w_nlanes;
    logic              w_accept;
    logic              w_issue;
    logic              w_handshake;
    logic              w_resp;
    logic              w_last_resp;
    int unsigned       w_op_sh;
    int unsigned       w_res_sh;
    logic [W8-1:0]     w_a8;
    logic [W8-1:0]     w_b8;
    logic [W16-1:0]    w_a16;
    logic [W16-1:0]    w_b16;
    logic [2*XLEN-1:0] w_mask;
    logic [2*XLEN-1:0] w_res;

    always_comb begin
        w_nlanes     = r_mode ? 3'd2 : 3'd4;
        w_accept     = clk_en_i && (r_state == StIdle) && data_valid_i;
        w_issue      = clk_en_i && (r_state == StRun) && (r_issue_cnt < w_nlanes) &&
                       (r_outstanding < 3'(MAX_OUTSTANDING));
        w_handshake  = w_issue && imul_ready_i;
        w_resp       = clk_en_i && (r_state == StRun) && imul_valid_i;
        w_last_resp  = w_resp && ((r_resp_cnt + 3'd1) == w_nlanes);

        // Lane select by shifting the latched operand down to bit 0.
        w_op_sh      = 32'(r_issue_cnt) * (r_mode ? W16 : W8);
        w_a8         = W8'(r_a >> w_op_sh);
        w_b8         = W8'(r_b >> w_op_sh);
        w_a16        = W16'(r_a >> w_op_sh);
        w_b16        = W16'(r_b >> w_op_sh);

        if (r_mode) begin
            imul_operand_a_o = {{(XLEN-W16){r_signed & w_a16[W16-1]}}, w_a16};
            imul_operand_b_o = {{(XLEN-W16){r_signed & w_b16[W16-1]}}, w_b16};
        end else begin
            imul_operand_a_o = {{(XLEN-W8){r_signed & w_a8[W8-1]}}, w_a8};
            imul_operand_b_o = {{(XLEN-W8){r_signed & w_b8[W8-1]}}, w_b8};
        end

        w_res_sh     = 32'(r_resp_cnt) * (r_mode ? XLEN : W16);
        w_mask       = r_mode ? (2*XLEN)'({XLEN{1'b1}}) : (2*XLEN)'({W16{1'b1}});
        w_res        = (2*XLEN)'(imul_result_i) & w_mask;

        imul_valid_o    = w_issue;
        imul_signed_o   = r_signed;
        busy_o          = (r_state != StIdle);
        vresult_valid_o = (r_state == StDone) && clk_en_i;
        vresult_o       = r_vresult;

        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (data_valid_i) w_state_next = StRun;
            StRun:   if (w_last_resp)  w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else if (clk_en_i) begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_a           <= '0;
            r_b           <= '0;
            r_mode        <= 1'b0;
            r_signed      <= 1'b0;
            r_issue_cnt   <= '0;
            r_resp_cnt    <= '0;
            r_outstanding <= '0;
            r_vresult     <= '0;
        end else if (w_accept) begin
            r_a           <= vmultiplicand_i;
            r_b           <= vmultiplier_i;
            r_mode        <= lane_mode_i;
            r_signed      <= signed_i;
            r_issue_cnt   <= '0;
            r_resp_cnt    <= '0;
            r_outstanding <= '0;
            r_vresult     <= '0;
        end else if (clk_en_i && (r_state == StRun)) begin
            if (w_handshake) begin
                r_issue_cnt <= r_issue_cnt + 3'd1;
            end
            if (w_resp) begin
                r_resp_cnt <= r_resp_cnt + 3'd1;
                r_vresult  <= (r_vresult & ~(w_mask << w_res_sh)) | (w_res << w_res_sh);
            end
            r_outstanding <= r_outstanding + {2'b00, w_handshake} - {2'b00, w_resp};
        end
    end

endmodule
